// File: rtl/rtype_sequencer_pkg.sv
// Shared types and constants for the R-type sequencer and its decoder.
package rtype_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam logic [5:0] R_TYPE    = 6'b000000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_OPCODE  = 2'b01,
    FC_FUNCT   = 2'b10,
    FC_TIMEOUT = 2'b11
  } fault_code_e;

  // Datapath control bundle, registered as one unit.
  typedef struct packed {
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] w);
    return w[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] w);
    return w[5:0];
  endfunction

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and imem.
interface rtype_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/rtype_sequencer_alu_funct_decoder.sv
// R-type funct field to ALU operation; legal=0 for any unsupported funct.
module alu_funct_decoder
  import rtype_sequencer_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  // Table lookup; illegal functs return ALUOP 000.
  always_comb begin
    alu_op = ALUOP_AND;
    legal  = 1'b1;
    case (funct)
      FUNCT_ADD: alu_op = ALUOP_ADD;
      FUNCT_SUB: alu_op = ALUOP_SUB;
      FUNCT_AND: alu_op = ALUOP_AND;
      FUNCT_OR:  alu_op = ALUOP_OR;
      FUNCT_SLT: alu_op = ALUOP_SLT;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type sequencer: fetch over req/ack, decode, execute,
// write back. Owns PC, IR, fetch wait counter and retired counter.
// All outputs are flops loaded from the next-state decode (Moore).
module rtype_sequencer
  import rtype_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  rtype_sequencer_if.master  imem,
  output logic [31:0]        instr,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               ALUsrc,
  output logic               RegWrite,
  output logic [2:0]         ALUOP,
  output logic               busy,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [CNT_W-1:0]   retired
);

  localparam int                WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TMO    = WCNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              stop_seen_q, stop_seen_d;
  fault_code_e       fc_q, fc_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;

  logic [2:0]        dec_op;
  logic              dec_legal;

  alu_funct_decoder u_dec (
    .funct  (funct_of(ir_q)),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  assign wcnt_inc = wcnt_q + WCNT_W'(1);

  // Next-state, datapath registers and registered-output decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    wcnt_d      = wcnt_q;
    ret_d       = ret_q;
    stop_seen_d = stop_seen_q;
    fc_d        = fc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          wcnt_d      = '0;
          // start+stop together: run exactly one instruction
          stop_seen_d = stop;
        end
      end
      S_FETCH: begin
        if (stop) stop_seen_d = 1'b1;
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = S_DECODE;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == TMO) begin
            state_d = S_FAULT;
            fc_d    = FC_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        if (stop) stop_seen_d = 1'b1;
        if (opcode_of(ir_q) != R_TYPE) begin
          state_d = S_FAULT;
          fc_d    = FC_OPCODE;
        end else if (!dec_legal) begin
          state_d = S_FAULT;
          fc_d    = FC_FUNCT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (stop) stop_seen_d = 1'b1;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d  = pc_q + ADDR_W'(4);
        ret_d = ret_q + CNT_W'(1);
        if (stop_seen_q || stop) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_FETCH;
          wcnt_d      = '0;
          stop_seen_d = 1'b0;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d == S_FETCH);
    busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
             (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);

    ctrl_d = '0;
    if (state_d == S_EXECUTE || state_d == S_WRITEBACK) begin
      ctrl_d.reg_dst   = 1'b1;
      ctrl_d.alu_op    = dec_op;
      ctrl_d.reg_write = (state_d == S_WRITEBACK);
    end
  end

  // State and output registers; async reset aborts any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      wcnt_q      <= '0;
      ret_q       <= '0;
      stop_seen_q <= 1'b0;
      fc_q        <= FC_NONE;
      ctrl_q      <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      wcnt_q      <= wcnt_d;
      ret_q       <= ret_d;
      stop_seen_q <= stop_seen_d;
      fc_q        <= fc_d;
      ctrl_q      <= ctrl_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = ir_q;
  assign RegDst         = ctrl_q.reg_dst;
  assign MemToReg       = ctrl_q.mem_to_reg;
  assign ALUsrc         = ctrl_q.alu_src;
  assign RegWrite       = ctrl_q.reg_write;
  assign ALUOP          = ctrl_q.alu_op;
  assign busy           = busy_q;
  assign fault          = (fc_q != FC_NONE);
  assign fault_code     = fc_q;
  assign retired        = ret_q;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Bench for rtype_sequencer: instruction-level reference model compared
// every cycle, plus hand-computed checks for each directed scenario.
module tb_rtype_sequencer;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          TIMEOUT  = 16;
  localparam int          CNT_W    = 16;

  localparam logic [31:0] W_ADD = 32'h012A4020;
  localparam logic [31:0] W_SUB = 32'h01095022;
  localparam logic [31:0] W_AND = 32'h01095024;
  localparam logic [31:0] W_OR  = 32'h01095025;
  localparam logic [31:0] W_SLT = 32'h0109502A;

  localparam logic [5:0] FN [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  localparam logic [2:0] OP [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] instr;
  logic RegDst, MemToReg, ALUsrc, RegWrite, busy, fault;
  logic [2:0] ALUOP;
  logic [1:0] fault_code;
  logic [CNT_W-1:0] retired;

  rtype_sequencer_if #(.ADDR_W(ADDR_W)) ifc ();

  rtype_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .imem(ifc.master),
    .instr(instr), .RegDst(RegDst), .MemToReg(MemToReg), .ALUsrc(ALUsrc),
    .RegWrite(RegWrite), .ALUOP(ALUOP), .busy(busy), .fault(fault),
    .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_op(input logic [5:0] f);
    for (int i = 0; i < 5; i++) if (FN[i] == f) return OP[i];
    return 3'b000;
  endfunction

  function automatic bit is_legal(input logic [5:0] f);
    for (int i = 0; i < 5; i++) if (FN[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Instruction memory responder: ack after ack_delay wait cycles.
  logic [31:0] mem [16];
  int ack_delay = 0;
  bit no_ack = 0, stray_ack = 0;
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    if (ifc.imem_req) begin
      ifc.imem_ack   = !no_ack && (rcnt == ack_delay);
      ifc.imem_rdata = mem[ifc.imem_addr[5:2]];
      rcnt++;
    end else begin
      ifc.imem_ack   = stray_ack;
      ifc.imem_rdata = 32'hFFFF_FFFF;
      rcnt = 0;
    end
  end

  // Reference model: per-instruction phase counter (0 fetch .. 3 writeback).
  bit m_run = 0, m_stop = 0;
  int m_age = 0, m_wait = 0;
  logic [31:0] m_ir = '0, m_pc = RESET_PC;
  logic [CNT_W-1:0] m_ret = '0;
  logic [1:0] m_code = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_stop <= 0; m_age <= 0; m_wait <= 0;
      m_ir <= '0; m_pc <= RESET_PC; m_ret <= '0; m_code <= '0;
    end else if (m_code == 2'd0) begin
      if (!m_run) begin
        if (start) begin m_run <= 1; m_age <= 0; m_wait <= 0; m_stop <= stop; end
      end else begin
        if (stop) m_stop <= 1;
        case (m_age)
          0: if (ifc.imem_ack) begin m_ir <= ifc.imem_rdata; m_age <= 1; end
             else begin m_wait <= m_wait + 1; if (m_wait + 1 >= TIMEOUT) m_code <= 2'd3; end
          1: if (m_ir[31:26] != 6'd0) m_code <= 2'd1;
             else if (!is_legal(m_ir[5:0])) m_code <= 2'd2;
             else m_age <= 2;
          2: m_age <= 3;
          default: begin
            m_pc <= m_pc + 32'd4; m_ret <= m_ret + 1'b1;
            if (m_stop || stop) m_run <= 0;
            else begin m_age <= 0; m_wait <= 0; m_stop <= 0; end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  logic bz;
  always @(negedge clk) begin
    bz = m_run && (m_code == 2'd0);
    chk("busy", busy, bz);
    chk("imem_req", ifc.imem_req, bz && m_age == 0);
    chk("imem_addr", ifc.imem_addr, m_pc);
    chk("instr", instr, m_ir);
    chk("RegDst", RegDst, bz && m_age >= 2);
    chk("RegWrite", RegWrite, bz && m_age == 3);
    chk("MemToReg", MemToReg, 1'b0);
    chk("ALUsrc", ALUsrc, 1'b0);
    chk("ALUOP", ALUOP, (bz && m_age >= 2) ? exp_op(m_ir[5:0]) : 3'b000);
    chk("fault", fault, m_code != 2'd0);
    chk("fault_code", fault_code, m_code);
    chk("retired", retired, m_ret);
  end

  // RegWrite pulse log: ALUOP and cycle of each writeback.
  int cyc = 0;
  logic [2:0] rw_op [$];
  int rw_cyc [$];
  always @(negedge clk) begin
    cyc++;
    if (RegWrite === 1'b1) begin rw_op.push_back(ALUOP); rw_cyc.push_back(cyc); end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; start = 0; stop = 0; no_ack = 0; stray_ack = 0; ack_delay = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  // Pulse start for one cycle; returns one time unit after the sampling edge.
  task automatic go(input bit s_stop);
    @(posedge clk); #1 start = 1; stop = s_stop;
    @(posedge clk); #1 start = 0; stop = 0;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int base;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    adv(1);
    chk("rst_busy", busy, 0); chk("rst_req", ifc.imem_req, 0);
    chk("rst_addr", ifc.imem_addr, RESET_PC); chk("rst_regwrite", RegWrite, 0);
    do_reset(); #1;
    chk("rel_instr", instr, 0); chk("rel_retired", retired, 0);
    chk("rel_fault_code", fault_code, 0); chk("rel_aluop", ALUOP, 0);

    // Single add with start+stop together
    mem[0] = W_ADD; base = rw_op.size();
    go(1);
    adv(2); chk("t1_rw_c3", RegWrite, 0); chk("t1_aluop", ALUOP, 3'b010); chk("t1_regdst", RegDst, 1);
    adv(1); chk("t1_rw_c4", RegWrite, 1); chk("t1_pc_wb", ifc.imem_addr, 0);
    adv(1); chk("t1_rw_c5", RegWrite, 0); chk("t1_busy", busy, 0);
    chk("t1_pc", ifc.imem_addr, 4); chk("t1_retired", retired, 1);

    // sub, and, or, slt back to back; stop raised during the last fetch
    do_reset();
    mem[0] = W_SUB; mem[1] = W_AND; mem[2] = W_OR; mem[3] = W_SLT;
    base = rw_op.size();
    go(0);
    adv(12); stop = 1;
    adv(1);  stop = 0;
    adv(3);
    chk("t2_busy", busy, 0); chk("t2_pc", ifc.imem_addr, 16); chk("t2_retired", retired, 4);
    chk("t2_nwb", rw_op.size() - base, 4);
    if (rw_op.size() - base == 4) begin
      chk("t2_op0", rw_op[base], 3'b110); chk("t2_op1", rw_op[base+1], 3'b000);
      chk("t2_op2", rw_op[base+2], 3'b001); chk("t2_op3", rw_op[base+3], 3'b111);
      for (int i = 1; i < 4; i++) chk("t2_spacing", rw_cyc[base+i] - rw_cyc[base+i-1], 4);
    end

    // ack delayed by 3 wait cycles
    do_reset(); mem[0] = W_ADD; ack_delay = 3;
    go(1);
    adv(3); chk("t3_req_c4", ifc.imem_req, 1); chk("t3_addr_c4", ifc.imem_addr, 0);
    adv(3); chk("t3_rw_c7", RegWrite, 1);
    adv(1); chk("t3_busy", busy, 0); chk("t3_retired", retired, 1);

    // ack arriving in the last allowed fetch cycle is still accepted
    do_reset(); mem[0] = W_ADD; ack_delay = TIMEOUT - 1;
    go(1);
    adv(TIMEOUT - 1); chk("t3b_req", ifc.imem_req, 1); chk("t3b_fault", fault, 0);
    adv(3); chk("t3b_rw", RegWrite, 1);
    adv(1); chk("t3b_fault_end", fault, 0); chk("t3b_retired", retired, 1);

    // fetch timeout
    do_reset(); no_ack = 1; base = rw_op.size();
    go(0);
    adv(TIMEOUT - 1); chk("t3c_req", ifc.imem_req, 1); chk("t3c_nofault", fault, 0);
    adv(1); chk("t3c_fault", fault, 1); chk("t3c_code", fault_code, 2'b11);
    chk("t3c_req_off", ifc.imem_req, 0); chk("t3c_pc", ifc.imem_addr, 0); chk("t3c_busy", busy, 0);

    // illegal opcode; fault is sticky and start is ignored
    do_reset(); mem[0] = 32'h8C000000; base = rw_op.size();
    go(0);
    adv(2); chk("t4_fault", fault, 1); chk("t4_code", fault_code, 2'b01);
    go(0);
    adv(3); chk("t4_sticky", fault_code, 2'b01); chk("t4_req", ifc.imem_req, 0);
    chk("t4_no_rw", rw_op.size() - base, 0);

    // illegal funct on the second instruction; PC frozen on it
    do_reset(); mem[0] = W_ADD; mem[1] = 32'h00000001;
    go(0);
    adv(6); chk("t4b_code", fault_code, 2'b10); chk("t4b_pc", ifc.imem_addr, 4);
    chk("t4b_retired", retired, 1);

    // stop pulsed during EXECUTE; then stop and stray ack in IDLE ignored
    do_reset(); mem[0] = W_ADD; mem[1] = W_SUB;
    go(0);
    adv(2); chk("t5_regdst_ex", RegDst, 1); stop = 1;
    adv(1); stop = 0; chk("t5_rw", RegWrite, 1);
    adv(1); chk("t5_busy", busy, 0); chk("t5_pc", ifc.imem_addr, 4); chk("t5_retired", retired, 1);
    stop = 1; stray_ack = 1;
    adv(3); chk("t5_idle_busy", busy, 0); chk("t5_idle_instr", instr, W_ADD);
    stop = 0; stray_ack = 0;

    // asynchronous reset during WRITEBACK
    do_reset(); mem[0] = W_ADD; mem[1] = W_ADD;
    go(0);
    adv(3); chk("t6_rw_before", RegWrite, 1);
    #1 rst_n = 0;
    #1;
    chk("t6_rw", RegWrite, 0); chk("t6_regdst", RegDst, 0); chk("t6_aluop", ALUOP, 0);
    chk("t6_busy", busy, 0); chk("t6_pc", ifc.imem_addr, RESET_PC);
    chk("t6_retired", retired, 0); chk("t6_instr", instr, 0);
    #3 rst_n = 1;
    adv(2); chk("t6_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
